// File: rtl/falu_cnv_i2f_stage.sv
// Two-stage shell around the combinational INT2FP converter: stage 1 drives the converter, stage 2 holds the result for writeback.
// Latency 2 cycles, 1 op/cycle; wb_* held under backpressure, req_ready drops once both stages are full.
module falu_cnv_i2f_stage #(
    parameter int TAG_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [2:0]       frm,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [63:0]      req_src,
    input  logic [2:0]       req_rm,
    input  logic             req_is_double,
    input  logic             req_is_word,
    input  logic             req_is_unsigned,
    input  logic [TAG_W-1:0] req_tag,
    output logic [63:0]      cnv_input,
    output logic [2:0]       cnv_rm,
    output logic             cnv_is_double,
    output logic             cnv_is_word,
    output logic             cnv_is_unsigned,
    input  logic [63:0]      cnv_output,
    input  logic             cnv_inexact,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [63:0]      wb_result,
    output logic [4:0]       wb_fflags,
    output logic             wb_illegal,
    output logic [TAG_W-1:0] wb_tag
);

    logic             v1;
    logic             v2;
    logic             ill1;
    logic [TAG_W-1:0] tag1;
    logic             adv1;
    logic             adv2;
    logic             accept;
    logic [2:0]       rm_eff;
    logic             rm_bad;

    assign adv2      = v2 & wb_ready;
    assign adv1      = v1 & (~v2 | adv2);
    assign req_ready = rst_n & ~flush & (~v1 | adv1);
    assign accept    = req_valid & req_ready;

    // Reserved modes (101/110/111 after DYN resolution) become illegal-instruction.
    assign rm_eff = (req_rm == 3'b111) ? frm : req_rm;
    assign rm_bad = (rm_eff == 3'b101) | (rm_eff == 3'b110) | (rm_eff == 3'b111);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1              <= 1'b0;
            ill1            <= 1'b0;
            tag1            <= '0;
            cnv_input       <= 64'd0;
            cnv_rm          <= 3'b000;
            cnv_is_double   <= 1'b0;
            cnv_is_word     <= 1'b0;
            cnv_is_unsigned <= 1'b0;
        end else begin
            v1 <= ~flush & (accept | (v1 & ~adv1));
            if (accept) begin
                ill1            <= rm_bad;
                tag1            <= req_tag;
                cnv_input       <= req_src;
                cnv_rm          <= rm_bad ? 3'b000 : rm_eff;
                cnv_is_double   <= req_is_double;
                cnv_is_word     <= req_is_word;
                cnv_is_unsigned <= req_is_unsigned;
            end
        end
    end

    // The payload may still load during a flush; v2 clearing hides it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2         <= 1'b0;
            wb_result  <= 64'd0;
            wb_fflags  <= 5'd0;
            wb_illegal <= 1'b0;
            wb_tag     <= '0;
        end else begin
            v2 <= ~flush & (adv1 | (v2 & ~adv2));
            if (adv1) begin
                wb_result  <= ill1 ? 64'd0 : cnv_output;
                wb_fflags  <= {4'b0000, ~ill1 & cnv_inexact};
                wb_illegal <= ill1;
                wb_tag     <= tag1;
            end
        end
    end

    assign wb_valid = v2;

endmodule
